tm_clause: RTL and testbench
============================

# tm_clause

Parametrised Tsetlin-machine clause: a bank of `NUM_LIT` Tsetlin automata with shared stochastic feedback. It evaluates the clause as the AND of all included literals. In training it applies Type I or Type II feedback serially, one automaton per cycle, using an internal LFSR for probabilistic updates. It sits under the clause-pool controller, which decides per-clause feedback enable and type.

## Interface
- `NUM_LIT`, default 8: number of literals and automata; ≥1.
- `STATE_BITS`, default 3: automaton state width. The include threshold is `2**(STATE_BITS-1)`.
- `PROB_BITS`, default 8: width of the probability compare; ≤16.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request one evaluation, plus feedback when enabled; accepted only in IDLE.
- `train` input 1: 1 selects training semantics and allows feedback; 0 selects inference only.
- `fb_en` input 1: this clause receives feedback this round.
- `fb_type` input 1: 0 selects Type I, 1 selects Type II.
- `literals` input `NUM_LIT`: literal vector.
- `prob_thresh` input `PROB_BITS`: probability 1/s scaled by 2^`PROB_BITS`.
- `seed_load` input 1: load `seed` into the LFSR; honoured in IDLE only.
- `seed` input 16: LFSR seed. A value of 0 is replaced by 16'hACE1.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse in DONE.
- `clause_out` output 1: registered clause result.
- `include_mask` output `NUM_LIT`: bit i = (state[i] ≥ threshold), combinational from the state registers.

## Operation
- States: IDLE, EVAL, FEEDBACK, DONE.
  - IDLE→EVAL on `start`.
  - EVAL→FEEDBACK if `train && fb_en`, else EVAL→DONE.
  - FEEDBACK→DONE after index `NUM_LIT-1`.
  - DONE→IDLE unconditionally.
- Inputs `train`, `fb_en`, `fb_type`, `literals` and `prob_thresh` are captured on the accepted `start` cycle. Later changes have no effect on the round.
- EVAL: `clause_out` <= AND over i of (!include[i] || lit[i]).
  - Empty clause (no includes) gives 1 if `train`, else 0.
- FEEDBACK visits index i = 0..`NUM_LIT-1`, one per cycle. It uses the captured literal, the registered `clause_out`, and state[i] as read in that cycle.
- The random draw for each visit is `hit` = (lfsr[`PROB_BITS`-1:0] < `prob_thresh`). A threshold of 0 means never hit.
- Type I:
  - Clause 1, literal 1: increment if !hit.
  - Clause 1, literal 0: decrement if hit.
  - Clause 0: decrement if hit.
- Type II: increment when clause is 1, literal is 0 and the automaton is excluded. Deterministic; otherwise no change.
- Saturation: states clamp at 0 and at 2^`STATE_BITS`-1. No wrap-around in either direction.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every `clk` cycle regardless of state.
  - `seed_load` overrides the step for that cycle.
- `start` while `busy` is ignored. This includes `start` in the DONE cycle; there is no queueing.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `clause_out`=0.
  - Every state = threshold-1, so `include_mask`=0.
  - LFSR = 16'hACE1; FSM = IDLE.
- Latency, with `start` sampled at edge 0:
  - EVAL is active in cycle 1.
  - `clause_out` is valid from cycle 2 and holds until the next EVAL.
  - Inference or no feedback: `done` is high in cycle 2.
  - Training with feedback: FEEDBACK spans cycles 2..`NUM_LIT`+1 and `done` is high in cycle `NUM_LIT`+2.
- State updates for index i land at the end of that index's FEEDBACK cycle. `include_mask` reflects each update on the next cycle.
- Reset mid-round aborts immediately. All registers return to reset values and no `done` is issued.

## Structure
- `tm_pkg` holds:
  - the FSM state enum;
  - the `FB_TYPE_I`/`FB_TYPE_II` constants;
  - the LFSR polynomial mask and default seed 16'hACE1.
- Sub-module `tm_lfsr`: 16-bit Galois LFSR with `clk`, `rst`, `load`, `seed`, `value`, including the zero-seed substitution.
- Automaton states are held as one packed array inside `tm_clause`. The feedback index counter is $clog2(`NUM_LIT`) bits wide.

## Test plan
All scenarios use `NUM_LIT`=4, `STATE_BITS`=3 (threshold 4, reset state 3, max 7), `PROB_BITS`=8.
- Reset, then inference `start` with literals 4'b1111 -> `clause_out`=0 (empty clause), `done` in cycle 2, `include_mask`=0000.
- Train, Type I, `prob_thresh`=0, literals 4'b1010 -> `clause_out`=1; states {3,4,3,4}, with the first entry being bit 0; `include_mask`=1010; `done` in cycle 6.
- Following that, train, Type II, literals 4'b1110 -> `clause_out`=1; bit 0 goes 3→4; `include_mask`=1011; other states unchanged.
- Saturation:
  - 10 rounds of Type I, `prob_thresh`=0, literals 1111 -> all states 7, no wrap.
  - Then 60 rounds of Type I, `prob_thresh`=255, literals 0000 -> all states 0 and stay 0.
- Handshake: `start` during FEEDBACK and in the DONE cycle is ignored, so exactly one `done` is issued. Changing literals mid-round does not change the updates.
- Reset asserted in the second FEEDBACK cycle -> `busy`=0, no `done`, states all 3, `clause_out`=0. A subsequent round behaves exactly as after power-on.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types and constants for the Tsetlin-machine clause and its LFSR.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tm_pkg;

    // Clause sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_FEEDBACK = 2'd2,
        ST_DONE     = 2'd3
    } tm_state_e;

    // Feedback type select, as driven on fb_type.
    localparam logic FB_TYPE_I  = 1'b0;
    localparam logic FB_TYPE_II = 1'b1;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/tm_lfsr.sv
// 16-bit Galois LFSR, free-running, with seed load (zero seed maps to the default).
// Latency: new value one cycle after each edge; load takes effect on the next edge.
// Backpressure: none; steps every clk cycle unless load is high.
// Ports: clk, rst (async, active-high), load, seed[15:0] in; value[15:0] out.
module tm_lfsr
    import tm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            // An all-zero state would lock the LFSR up, so substitute the default.
            value <= (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/tm_clause.sv
// Tsetlin-machine clause: NUM_LIT automata, AND-of-included-literals eval, serial Type I/II feedback.
// Latency: clause_out/done in cycle 2 after start; with feedback done in cycle NUM_LIT+2.
// Backpressure: start accepted only in IDLE (busy low); start while busy is dropped, not queued.
// Ports: clk, rst, start, train, fb_en, fb_type, literals, prob_thresh, seed_load, seed in;
//        busy, done, clause_out, include_mask out.
module tm_clause
    import tm_pkg::*;
#(
    parameter int NUM_LIT    = 8,
    parameter int STATE_BITS = 3,
    parameter int PROB_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 train,
    input  logic                 fb_en,
    input  logic                 fb_type,
    input  logic [NUM_LIT-1:0]   literals,
    input  logic [PROB_BITS-1:0] prob_thresh,
    input  logic                 seed_load,
    input  logic [15:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic                 clause_out,
    output logic [NUM_LIT-1:0]   include_mask
);

    // A single-literal clause still needs a 1-bit index register.
    localparam int IDX_W = (NUM_LIT > 1) ? $clog2(NUM_LIT) : 1;

    localparam logic [STATE_BITS-1:0] THRESH   = STATE_BITS'(2 ** (STATE_BITS - 1));
    localparam logic [STATE_BITS-1:0] TA_RST   = STATE_BITS'(2 ** (STATE_BITS - 1) - 1);
    localparam logic [STATE_BITS-1:0] TA_MAX   = '1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_LIT - 1);

    tm_state_e state, state_nxt;

    logic [NUM_LIT-1:0][STATE_BITS-1:0] ta_state;
    logic [IDX_W-1:0]                   fb_idx;

    // Round parameters frozen at the accepted start.
    logic                 cap_train;
    logic                 cap_fb_en;
    logic                 cap_fb_type;
    logic [NUM_LIT-1:0]   cap_lit;
    logic [PROB_BITS-1:0] cap_thresh;

    logic [15:0] lfsr_val;
    logic        lfsr_unused;
    logic        accept;
    logic        eval_res;
    logic        hit;
    logic        ta_inc;
    logic        ta_dec;
    logic [STATE_BITS-1:0] ta_cur;
    logic [STATE_BITS-1:0] ta_nxt;
    logic        lit_cur;

    assign accept = (state == ST_IDLE) && start;

    tm_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (seed_load && (state == ST_IDLE)),
        .seed  (seed),
        .value (lfsr_val)
    );

    // Only the low PROB_BITS feed the compare; the rest just keep the sequence long.
    assign lfsr_unused = ^lfsr_val;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LIT; gi++) begin : g_inc
            assign include_mask[gi] = (ta_state[gi] >= THRESH);
        end
    endgenerate

    // Empty clause votes 1 while training so that feedback can grow it,
    // but must not fire during inference.
    always_comb begin
        eval_res = &(~include_mask | cap_lit);
        if (include_mask == '0) begin
            eval_res = cap_train;
        end
    end

    // Feedback for the automaton currently addressed by fb_idx.
    always_comb begin
        ta_cur  = ta_state[fb_idx];
        lit_cur = cap_lit[fb_idx];
        hit     = (lfsr_val[PROB_BITS-1:0] < cap_thresh);
        ta_inc  = 1'b0;
        ta_dec  = 1'b0;
        if (cap_fb_type == FB_TYPE_I) begin
            if (clause_out && lit_cur) begin
                ta_inc = !hit;
            end else begin
                ta_dec = hit;
            end
        end else begin
            ta_inc = clause_out && !lit_cur && (ta_cur < THRESH);
        end
        ta_nxt = ta_cur;
        if (ta_inc && (ta_cur != TA_MAX)) begin
            ta_nxt = ta_cur + STATE_BITS'(1);
        end else if (ta_dec && (ta_cur != '0)) begin
            ta_nxt = ta_cur - STATE_BITS'(1);
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_EVAL;
            ST_EVAL:     state_nxt = (cap_train && cap_fb_en) ? ST_FEEDBACK : ST_DONE;
            ST_FEEDBACK: if (fb_idx == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Datapath: capture, evaluation and per-automaton updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_train   <= 1'b0;
            cap_fb_en   <= 1'b0;
            cap_fb_type <= FB_TYPE_I;
            cap_lit     <= '0;
            cap_thresh  <= '0;
            clause_out  <= 1'b0;
            fb_idx      <= '0;
            ta_state    <= {NUM_LIT{TA_RST}};
        end else begin
            if (accept) begin
                cap_train   <= train;
                cap_fb_en   <= fb_en;
                cap_fb_type <= fb_type;
                cap_lit     <= literals;
                cap_thresh  <= prob_thresh;
            end
            if (state == ST_EVAL) begin
                clause_out <= eval_res;
                fb_idx     <= '0;
            end
            if (state == ST_FEEDBACK) begin
                ta_state[fb_idx] <= ta_nxt;
                fb_idx           <= fb_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tm_clause.sv
// Directed bench for tm_clause with NUM_LIT=4, STATE_BITS=3, PROB_BITS=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_tm_clause;
    import tm_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       train;
    logic       fb_en;
    logic       fb_type;
    logic [3:0] literals;
    logic [7:0] prob_thresh;
    logic       seed_load;
    logic [15:0] seed;
    logic       busy;
    logic       done;
    logic       clause_out;
    logic [3:0] include_mask;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done;

    tm_clause #(
        .NUM_LIT    (4),
        .STATE_BITS (3),
        .PROB_BITS  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .train        (train),
        .fb_en        (fb_en),
        .fb_type      (fb_type),
        .literals     (literals),
        .prob_thresh  (prob_thresh),
        .seed_load    (seed_load),
        .seed         (seed),
        .busy         (busy),
        .done         (done),
        .clause_out   (clause_out),
        .include_mask (include_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Issue one round starting just after a rising edge; returns aligned just after
    // the edge that leaves DONE.
    task automatic run_round(input string tag, input logic tr, input logic fe, input logic ft,
                             input logic [3:0] lits, input logic [7:0] th,
                             input int exp_cyc, input logic exp_clause);
        int done_cyc;
        logic busy_c1;
        logic clause_at_done;
        done_cyc       = 0;
        busy_c1        = 1'b0;
        clause_at_done = 1'bx;
        train       = tr;
        fb_en       = fe;
        fb_type     = ft;
        literals    = lits;
        prob_thresh = th;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) busy_c1 = busy;
            if (done) begin
                done_cyc       = c;
                clause_at_done = clause_out;
                break;
            end
        end
        check({tag, "_busy_c1"}, {31'd0, busy_c1}, 32'd1);
        check({tag, "_done_cyc"}, done_cyc, exp_cyc);
        check({tag, "_clause"}, {31'd0, clause_at_done}, {31'd0, exp_clause});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        train       = 1'b0;
        fb_en       = 1'b0;
        fb_type     = FB_TYPE_I;
        literals    = 4'b0000;
        prob_thresh = 8'd0;
        seed_load   = 1'b0;
        seed        = 16'h0000;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_clause", {31'd0, clause_out}, 32'd0);
        check("rst_mask", {28'd0, include_mask}, 32'h0);
        check("rst_states", {20'd0, dut.ta_state}, 32'h6DB);
        check("rst_lfsr", {16'd0, dut.lfsr_val}, 32'hACE1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Inference on an empty clause yields 0.
        run_round("inf_empty", 1'b0, 1'b0, FB_TYPE_I, 4'b1111, 8'd0, 2, 1'b0);
        check("inf_empty_mask", {28'd0, include_mask}, 32'h0);

        // Type I, never hit: literal-1 automata step up, literal-0 ones hold.
        run_round("t1_1010", 1'b1, 1'b1, FB_TYPE_I, 4'b1010, 8'd0, 6, 1'b1);
        check("t1_1010_states", {20'd0, dut.ta_state}, 32'h8E3);
        check("t1_1010_mask", {28'd0, include_mask}, 32'hA);

        // Type II: only bit 0 (literal 0, excluded) moves up.
        run_round("t2_1110", 1'b1, 1'b1, FB_TYPE_II, 4'b1110, 8'd0, 6, 1'b1);
        check("t2_1110_states", {20'd0, dut.ta_state}, 32'h8E4);
        check("t2_1110_mask", {28'd0, include_mask}, 32'hB);

        // Training without feedback enable: no state change, included literals 0 -> clause 0.
        run_round("nofb", 1'b1, 1'b0, FB_TYPE_I, 4'b0000, 8'd0, 2, 1'b0);
        check("nofb_states", {20'd0, dut.ta_state}, 32'h8E4);

        // Inference with all included literals true.
        run_round("inf_1011", 1'b0, 1'b0, FB_TYPE_I, 4'b1011, 8'd0, 2, 1'b1);

        // Saturate upward.
        for (int r = 0; r < 10; r++)
            run_round("sat_up", 1'b1, 1'b1, FB_TYPE_I, 4'b1111, 8'd0, 6, 1'b1);
        check("sat_up_states", {20'd0, dut.ta_state}, 32'hFFF);
        check("sat_up_mask", {28'd0, include_mask}, 32'hF);

        // Saturate downward; clause value drifts, so only timing is tracked per round.
        for (int r = 0; r < 60; r++) begin
            train = 1'b1; fb_en = 1'b1; fb_type = FB_TYPE_I;
            literals = 4'b0000; prob_thresh = 8'd255;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n_done = 0;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                if (done) n_done = c;
                @(posedge clk);
                #1;
            end
            check("sat_dn_done_cyc", n_done, 6);
        end
        check("sat_dn_states", {20'd0, dut.ta_state}, 32'h000);
        check("sat_dn_mask", {28'd0, include_mask}, 32'h0);

        // Handshake: start held through FEEDBACK and DONE; inputs changed mid-round.
        train = 1'b1; fb_en = 1'b1; fb_type = FB_TYPE_I;
        literals = 4'b1111; prob_thresh = 8'd0;
        start = 1'b1;
        n_done = 0;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 3) begin
                literals    = 4'b0000;
                fb_type     = FB_TYPE_II;
                prob_thresh = 8'd255;
            end
            if (done) n_done++;
            @(posedge clk);
            #1;
            if (c == 6) start = 1'b0;
        end
        check("hs_done_count", n_done, 1);
        check("hs_states", {20'd0, dut.ta_state}, 32'h249);
        check("hs_idle", {31'd0, busy}, 32'd0);

        // Reset in the second FEEDBACK cycle.
        train = 1'b1; fb_en = 1'b1; fb_type = FB_TYPE_I;
        literals = 4'b1111; prob_thresh = 8'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);          // cycle 1
        @(negedge clk);          // cycle 2
        @(negedge clk);          // cycle 3
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_clause", {31'd0, clause_out}, 32'd0);
        check("mid_rst_states", {20'd0, dut.ta_state}, 32'h6DB);
        check("mid_rst_mask", {28'd0, include_mask}, 32'h0);
        check("mid_rst_lfsr", {16'd0, dut.lfsr_val}, 32'hACE1);
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid_rst_no_done", n_done, 0);
        @(posedge clk);
        #1;

        // Same round as the first training round after power-on.
        run_round("post_rst", 1'b1, 1'b1, FB_TYPE_I, 4'b1010, 8'd0, 6, 1'b1);
        check("post_rst_states", {20'd0, dut.ta_state}, 32'h8E3);
        check("post_rst_mask", {28'd0, include_mask}, 32'hA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
